// File: rtl/card_tile_writer.sv
// card_tile_writer: accepts DRAW/ERASE/CLEAR/BYPASS commands and issues
// one registered video-slot write per cycle for the selected tiles.
module card_tile_writer #(
  parameter int         CARD_W     = 2,
  parameter int         CARD_H     = 3,
  parameter logic [5:0] BLANK_CODE = 6'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_xt,
  input  logic [2:0]  cmd_yt,
  input  logic [5:0]  cmd_code,
  output logic        cs,
  output logic        write,
  output logic [13:0] addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done
);

  localparam int CW = (CARD_W > 1) ? $clog2(CARD_W) : 1;
  localparam int RH = (CARD_H > 1) ? $clog2(CARD_H) : 1;

  localparam logic [1:0] OP_DRAW   = 2'b00;
  localparam logic [1:0] OP_ERASE  = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_BYPASS = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CARD   = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_BYPASS = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  state_t          state_r, state_next_s;
  logic [1:0]      op_r;
  logic [4:0]      xt_r;
  logic [2:0]      yt_r;
  logic [5:0]      code_r;
  logic [RH-1:0]   row_r, row_next_s;
  logic [CW-1:0]   col_r, col_next_s;
  logic [7:0]      idx_r, idx_next_s;

  // Fields in effect for the slot being prepared: live inputs on the
  // acceptance cycle, latched copies afterwards.
  logic            accept_s;
  logic [1:0]      op_s;
  logic [4:0]      xt_s;
  logic [2:0]      yt_s;
  logic [5:0]      code_s;
  logic [5:0]      xt_sum_s;
  logic [3:0]      yt_sum_s;
  logic [5:0]      draw_code_s;

  logic            cs_next_s, write_next_s, busy_next_s, done_next_s;
  logic [13:0]     addr_next_s;
  logic [31:0]     wr_data_next_s;

  assign cmd_ready = (state_r == ST_IDLE);
  assign accept_s  = cmd_valid && cmd_ready;
  assign op_s      = accept_s ? cmd_op   : op_r;
  assign xt_s      = accept_s ? cmd_xt   : xt_r;
  assign yt_s      = accept_s ? cmd_yt   : yt_r;
  assign code_s    = accept_s ? cmd_code : code_r;

  // Next-state and slot-counter sequencing.
  always_comb begin
    state_next_s = state_r;
    row_next_s   = row_r;
    col_next_s   = col_r;
    idx_next_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          row_next_s = '0;
          col_next_s = '0;
          idx_next_s = 8'd0;
          case (cmd_op)
            OP_DRAW, OP_ERASE: state_next_s = ST_CARD;
            OP_CLEAR:          state_next_s = ST_CLEAR;
            OP_BYPASS:         state_next_s = ST_BYPASS;
            default:           state_next_s = ST_IDLE;
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CARD: begin
        if (col_r == CW'(CARD_W - 1)) begin
          col_next_s = '0;
          if (row_r == RH'(CARD_H - 1)) begin
            state_next_s = ST_FIN;
          end else begin
            row_next_s = row_r + RH'(1);
          end
        end else begin
          col_next_s = col_r + CW'(1);
        end
      end
      ST_CLEAR: begin
        if (idx_r == 8'd255) begin
          state_next_s = ST_FIN;
        end else begin
          idx_next_s = idx_r + 8'd1;
        end
      end
      ST_BYPASS: state_next_s = ST_FIN;
      ST_FIN:    state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Bus values for the slot the FSM is about to enter; registered below.
  always_comb begin
    cs_next_s      = 1'b0;
    write_next_s   = 1'b0;
    addr_next_s    = 14'd0;
    wr_data_next_s = 32'd0;
    busy_next_s    = (state_next_s != ST_IDLE);
    done_next_s    = (state_next_s == ST_FIN);
    xt_sum_s       = {1'b0, xt_s} + 6'(col_next_s);
    yt_sum_s       = {1'b0, yt_s} + 4'(row_next_s);
    draw_code_s    = code_s + 6'(32'(row_next_s) * 32'(CARD_W) + 32'(col_next_s));
    case (state_next_s)
      ST_CARD: begin
        if ((xt_sum_s <= 6'd31) && (yt_sum_s <= 4'd7)) begin
          cs_next_s    = 1'b1;
          write_next_s = 1'b1;
          addr_next_s  = {6'd0, yt_sum_s[2:0], xt_sum_s[4:0]};
          if (op_s == OP_DRAW) begin
            wr_data_next_s = {26'd0, draw_code_s};
          end else begin
            wr_data_next_s = {26'd0, BLANK_CODE};
          end
        end else begin
          cs_next_s    = 1'b0;
          write_next_s = 1'b0;
        end
      end
      ST_CLEAR: begin
        cs_next_s      = 1'b1;
        write_next_s   = 1'b1;
        addr_next_s    = {6'd0, idx_next_s};
        wr_data_next_s = {26'd0, BLANK_CODE};
      end
      ST_BYPASS: begin
        cs_next_s      = 1'b1;
        write_next_s   = 1'b1;
        addr_next_s    = 14'h2000;
        wr_data_next_s = {31'd0, code_s[0]};
      end
      default: begin
        cs_next_s    = 1'b0;
        write_next_s = 1'b0;
      end
    endcase
  end

  // State, counters and command fields; fields latch only on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      row_r   <= '0;
      col_r   <= '0;
      idx_r   <= 8'd0;
      op_r    <= 2'd0;
      xt_r    <= 5'd0;
      yt_r    <= 3'd0;
      code_r  <= 6'd0;
    end else begin
      state_r <= state_next_s;
      row_r   <= row_next_s;
      col_r   <= col_next_s;
      idx_r   <= idx_next_s;
      if (accept_s) begin
        op_r   <= cmd_op;
        xt_r   <= cmd_xt;
        yt_r   <= cmd_yt;
        code_r <= cmd_code;
      end
    end
  end

  // Registered bus and status outputs; reset clears them immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs      <= 1'b0;
      write   <= 1'b0;
      addr    <= 14'd0;
      wr_data <= 32'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      cs      <= cs_next_s;
      write   <= write_next_s;
      addr    <= addr_next_s;
      wr_data <= wr_data_next_s;
      busy    <= busy_next_s;
      done    <= done_next_s;
    end
  end

endmodule

// File: doc/card_tile_writer.md
CARD_TILE_WRITER -- requirements
Module: card_tile_writer

Interface
REQ-001 The parameter CARD_W SHALL default to 2 and sets the card width in tiles.
REQ-002 The parameter CARD_H SHALL default to 3 and sets the card height in tiles.
REQ-003 The parameter BLANK_CODE SHALL default to 0 and is the 6-bit tile code written on erase and clear.
REQ-004 Port clk SHALL be an input of 1 bit and is the system clock; all state changes on its rising edge.
REQ-005 Port reset SHALL be an input of 1 bit; reset is asynchronous and active-high.
REQ-006 Port cmd_valid SHALL be an input of 1 bit and means a command is offered.
REQ-007 Port cmd_ready SHALL be an output of 1 bit and means a command can be accepted this cycle.
REQ-008 Port cmd_op SHALL be an input of 2 bits: 00 DRAW, 01 ERASE, 10 CLEAR, 11 BYPASS.
REQ-009 Port cmd_xt SHALL be an input of 5 bits and is the card top-left tile column, 0-31.
REQ-010 Port cmd_yt SHALL be an input of 3 bits and is the card top-left tile row, 0-7.
REQ-011 Port cmd_code SHALL be an input of 6 bits: the DRAW base tile code, or bit 0 as the BYPASS value.
REQ-012 Port cs SHALL be an output of 1 bit and is the video slot select.
REQ-013 Port write SHALL be an output of 1 bit and is the video slot write strobe.
REQ-014 Port addr SHALL be an output of 14 bits: bit 13 = 1 selects a register; otherwise [7:5] is the tile row and [4:0] the tile column.
REQ-015 Port wr_data SHALL be an output of 32 bits and is the slot write data.
REQ-016 Port busy SHALL be an output of 1 bit and is high while a command is executing.
REQ-017 Port done SHALL be an output of 1 bit and pulses for one cycle when a command completes.

Function
REQ-018 cmd_ready SHALL be high only in IDLE; a command is accepted on the cycle where cmd_valid and cmd_ready are both high, and cmd fields are latched on that cycle.
REQ-019 The FSM SHALL have the states IDLE, CARD, CLEAR, BYPASS and FIN; acceptance moves IDLE to CARD (DRAW or ERASE), CLEAR or BYPASS.
REQ-020 All bus outputs SHALL be registered; the first write cycle SHALL occur on the cycle after acceptance.
REQ-021 A write cycle SHALL drive cs=1 and write=1 for exactly one cycle; outside write cycles cs, write, addr and wr_data SHALL be 0.
REQ-022 CARD SHALL step row r = 0..CARD_H-1 (outer loop) and col c = 0..CARD_W-1 (inner loop), one slot per cycle, CARD_W*CARD_H cycles in total.
REQ-023 For each slot, the target tile SHALL be xt = cmd_xt+c and yt = cmd_yt+r, computed 1 bit wider than the field.
REQ-024 If xt > 31 or yt > 7, the slot SHALL be clipped: cs=write=0, the cycle is still consumed, and coordinates do not wrap.
REQ-025 A non-clipped slot SHALL drive addr = {6'b0, yt[2:0], xt[4:0]} with addr[13]=0.
REQ-026 For DRAW, wr_data[5:0] SHALL be (cmd_code + r*CARD_W + c) mod 64; for ERASE, wr_data[5:0] SHALL be BLANK_CODE; wr_data[31:6] SHALL be 0 in both cases.
REQ-027 CLEAR SHALL write BLANK_CODE to all 256 tiles in 256 consecutive cycles, with column fastest: (0,0),(1,0)..(31,0),(0,1)..(31,7).
REQ-028 BYPASS SHALL issue one write with addr = 14'h2000 and wr_data = {31'b0, cmd_code[0]}.
REQ-029 After the last slot, the FSM SHALL go to FIN for one cycle with done=1, then return to IDLE.
REQ-030 busy SHALL be high from the cycle after acceptance through FIN inclusive; busy and cmd_ready SHALL never both be high.
REQ-031 Total latency from acceptance to the done cycle SHALL be N+1 cycles, where N = 6 (card at default), 256 (CLEAR) or 1 (BYPASS).
REQ-032 cmd_valid while busy SHALL be ignored and SHALL NOT be latched; the offering side holds it until cmd_ready.
REQ-033 A command offered on the same cycle as FIN SHALL NOT be accepted; it is accepted in the following IDLE cycle.

Reset
REQ-034 On reset, the FSM SHALL go to IDLE and cs, write, addr, wr_data, busy and done SHALL be 0; cmd_ready SHALL be 1 after reset is released.
REQ-035 Reset asserted mid-command SHALL abort the command immediately with no further writes, and no done pulse is generated.

Verification
REQ-036 DRAW at xt=4, yt=2, code=10 -> writes at cycles 1-6 to (4,2)=10, (5,2)=11, (4,3)=12, (5,3)=13, (4,4)=14, (5,4)=15; done at cycle 7.
REQ-037 DRAW at xt=31, yt=6, code=62 -> only (31,6)=62 and (31,7)=0 are written (the code wraps mod 64); the other 4 slots are clipped; done still at cycle 7.
REQ-038 CLEAR -> exactly 256 writes of 0, first to addr 0x000 and last to 0x0FF; done at cycle 257; cmd_ready=0 throughout.
REQ-039 BYPASS with code[0]=1 -> one write to addr 0x2000 with data 0x00000001, done at cycle 2; a second DRAW offered during busy is accepted only after done.
REQ-040 Reset asserted at cycle 3 of a DRAW -> all outputs 0 at once, no done pulse; cmd_ready=1 after release, and a new command executes normally.
